// File: rtl/led_pwm_ctrl.sv
// Memory-mapped multi-channel PWM controller for board LEDs with active-low outputs.
// Optional hardware triangle fade is built when LED_PWM_FADE_EN is defined.
module led_pwm_ctrl #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned PWM_WIDTH   = 8,
    parameter int unsigned PRESC_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic              re,
    input  logic [4:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] pwm_n
);

    localparam logic [4:0]           ADDR_CTRL   = 5'd0;
    localparam logic [4:0]           ADDR_STATUS = 5'd1;
    localparam logic [4:0]           ADDR_FADE   = 5'(2 + NUM_CH);
    localparam logic [PWM_WIDTH-1:0] CNT_MAX     = '1;

    logic                   en_q, en_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [PWM_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PWM_WIDTH-1:0]   shadow_q [NUM_CH];
    logic [PWM_WIDTH-1:0]   shadow_d [NUM_CH];
    logic [PWM_WIDTH-1:0]   act_q [NUM_CH];
    logic [PWM_WIDTH-1:0]   act_d [NUM_CH];
    logic [31:0]            rdata_q, rdata_d;
    logic [NUM_CH-1:0]      pwm_n_q, pwm_n_d;
`ifdef LED_PWM_FADE_EN
    logic [NUM_CH-1:0]      fade_q, fade_d;
    logic [NUM_CH-1:0]      dir_q, dir_d;
`endif

    logic        wr_c;
    logic        tick_c;
    logic        wrap_c;
    logic [31:0] rd_val_c;
    logic        unused_wdata_c;

    assign wr_c           = sel & we;
    assign unused_wdata_c = ^wdata;

    // Register writes, prescaler, period counter and active-duty update.
    always_comb begin
        en_d        = en_q;
        presc_d     = presc_q;
        shadow_d    = shadow_q;
        act_d       = act_q;
        presc_cnt_d = presc_cnt_q;
        cnt_d       = cnt_q;
`ifdef LED_PWM_FADE_EN
        fade_d      = fade_q;
        dir_d       = dir_q;
        if (wr_c && addr == ADDR_FADE) fade_d = wdata[NUM_CH-1:0];
`endif
        if (wr_c && addr == ADDR_CTRL) begin
            en_d    = wdata[0];
            presc_d = wdata[PRESC_WIDTH+7:8];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_c && addr == 5'(2 + i)) shadow_d[i] = wdata[PWM_WIDTH-1:0];
        end

        tick_c = en_q && (presc_cnt_q == presc_q);
        wrap_c = tick_c && (cnt_q == CNT_MAX);

        // A count already past a newly lowered presc falls back to 0 without a tick.
        if (!en_q || presc_cnt_q >= presc_q) presc_cnt_d = '0;
        else                                 presc_cnt_d = presc_cnt_q + PRESC_WIDTH'(1);

        if (!en_q)       cnt_d = '0;
        else if (tick_c) cnt_d = cnt_q + PWM_WIDTH'(1);

        for (int i = 0; i < NUM_CH; i++) begin
            if (!en_q) begin
                act_d[i] = en_d ? shadow_q[i] : '0;
`ifdef LED_PWM_FADE_EN
                dir_d[i] = 1'b0;
`endif
            end else if (wrap_c) begin
`ifdef LED_PWM_FADE_EN
                if (!fade_q[i]) begin
                    act_d[i] = shadow_q[i];
                    dir_d[i] = 1'b0;
                end else if (shadow_q[i] == '0) begin
                    act_d[i] = '0;
                    dir_d[i] = 1'b0;
                end else if (!dir_q[i]) begin
                    if (act_q[i] < shadow_q[i]) begin
                        act_d[i] = act_q[i] + PWM_WIDTH'(1);
                    end else begin
                        act_d[i] = act_q[i] - PWM_WIDTH'(1);
                        dir_d[i] = 1'b1;
                    end
                end else begin
                    if (act_q[i] != '0) begin
                        act_d[i] = act_q[i] - PWM_WIDTH'(1);
                    end else begin
                        act_d[i] = act_q[i] + PWM_WIDTH'(1);
                        dir_d[i] = 1'b0;
                    end
                end
`else
                act_d[i] = shadow_q[i];
`endif
            end
        end
    end

    // Read mux from current register state, so a same-cycle write reads the old value.
    always_comb begin
        rd_val_c = '0;
        if (addr == ADDR_CTRL) begin
            rd_val_c[0]                = en_q;
            rd_val_c[PRESC_WIDTH+7:8]  = presc_q;
        end else if (addr == ADDR_STATUS) begin
            rd_val_c[PWM_WIDTH-1:0] = cnt_q;
        end
`ifdef LED_PWM_FADE_EN
        if (addr == ADDR_FADE) rd_val_c[NUM_CH-1:0] = fade_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == 5'(2 + i)) rd_val_c[PWM_WIDTH-1:0] = shadow_q[i];
        end
        rdata_d = (sel && re) ? rd_val_c : rdata_q;
    end

    always_comb begin
        pwm_n_d = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_n_d[i] = ~(en_q && (cnt_q < act_q[i]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q        <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            pwm_n_q     <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                act_q[i]    <= '0;
            end
`ifdef LED_PWM_FADE_EN
            fade_q      <= '0;
            dir_q       <= '0;
`endif
        end else begin
            en_q        <= en_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            pwm_n_q     <= pwm_n_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                act_q[i]    <= act_d[i];
            end
`ifdef LED_PWM_FADE_EN
            fade_q      <= fade_d;
            dir_q       <= dir_d;
`endif
        end
    end

    assign rdata = rdata_q;
    assign pwm_n = pwm_n_q;

endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Memory-mapped, multi-channel PWM controller for the board's status LED and RGB LED. It is the parametrised successor to driving static LED/RGB bits straight from the datapath. It sits on the datapath's data-memory bus alongside data RAM and decodes a small word-addressed register window. It generates `NUM_CH` independent, glitch-free PWM outputs with programmable duty, a shared prescaler and optional hardware fade. Outputs are active-low to match the board LEDs.

## Interface
- `NUM_CH`, 4: number of PWM channels (1–16); ch0=LED, ch1..3=R,G,B on the current board.
- `PWM_WIDTH`, 8: duty/counter width in bits (4–16); period = 2^PWM_WIDTH ticks.
- `PRESC_WIDTH`, 16: prescaler field width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sel`  in  1  bus select; this window is addressed.
- `we`  in  1  write strobe, qualified by `sel`.
- `re`  in  1  read strobe, qualified by `sel`.
- `addr`  in  5  word index within the window.
- `wdata`  in  32  write data.
- `rdata`  out  32  registered read data.
- `pwm_n`  out  NUM_CH  PWM outputs, active-low (0 = LED lit).

## Operation
- Register map (word index):
  - 0 CTRL: bit0 `en`; bits[PRESC_WIDTH+7:8] `presc`.
  - 1 STATUS (RO): bits[PWM_WIDTH-1:0] current PWM counter.
  - 2..2+NUM_CH-1 DUTY[i]: bits[PWM_WIDTH-1:0] shadow duty.
  - 2+NUM_CH FADE: bit i = fade enable for channel i.
- Unmapped addresses read 0; writes to them or to STATUS are ignored. Upper unused bits read 0.
- Prescaler counts 0..`presc`. A `tick` is asserted for one cycle when the count equals `presc`, and the prescaler then returns to 0. `presc`=0 gives a tick every cycle.
- PWM counter increments on `tick` and wraps from 2^PWM_WIDTH−1 to 0.
- `wrap` = `tick` while the counter equals 2^PWM_WIDTH−1.
- Each channel has an active duty register, which is loaded from its shadow at `wrap`. Bus writes only touch the shadow, so a period is never truncated.
- Channel i is lit while counter < active_duty[i]:
  - duty 0 = never lit.
  - duty 2^W−1 = lit 2^W−1 of 2^W ticks.
- `en`=0: prescaler and counter are held at 0, active duties are cleared, `pwm_n` is all 1s. Shadows and registers stay writable.
- On the 0→1 transition of `en`, every active duty loads its shadow immediately.

## Timing
- Reset values: all registers 0, `rdata`=0, `pwm_n`=all 1s.
- Reset is asynchronous at any point, including mid-period, and returns the block to these values immediately.
- Writes take effect in the register at the `clk` edge where `sel&we`.
- Reads: `rdata` is updated at the edge where `sel&re` (1-cycle latency) and holds its value otherwise.
- Read and write to the same address in one cycle: `rdata` returns the pre-write value.
- `pwm_n` is registered: it reflects the comparison of the counter and active duty from the previous cycle (1-cycle latency).
- A DUTY write in the same cycle as `wrap`: active loads the old shadow; the new value applies from the following period.
- A `presc` change takes effect from the next prescaler count; an in-progress count that already exceeds the new `presc` wraps to 0 on the next cycle.

## Configuration
- `LED_PWM_FADE_EN` defined: channels whose FADE bit is set ignore shadow loading at `wrap`. Instead:
  - At each `wrap`, active duty steps by ±1, forming a triangle ramp between 0 and the shadow value.
  - The direction flips at each bound; a per-channel direction bit resets to "up".
  - Shadow 0 holds the active duty at 0.
  - Clearing the FADE bit reloads the shadow at the next `wrap`.
- `LED_PWM_FADE_EN` not defined: no fade logic is built, the FADE register reads 0 and ignores writes, and all channels use plain shadow loading.

## Test plan
- Reset, then hold `reset`=1 mid-run -> `pwm_n`=4'b1111, `rdata`=0, all registers read 0.
- NUM_CH=4, W=8, `presc`=0, en=1, DUTY0=64 -> `pwm_n[0]`=0 for exactly 64 of every 256 cycles; other channels stay 1.
- DUTY1=0 and DUTY2=255 -> `pwm_n[1]` is never 0; `pwm_n[2]` is 0 for 255 of every 256 cycles.
- `presc`=3, DUTY3=2 -> tick every 4 cycles; `pwm_n[3]` is low for 8 cycles per 1024-cycle period.
- Write DUTY0=200 while counter=100, with a second write coinciding with `wrap` -> the current period still uses the old duty, and the new duty starts exactly at the next wrap; readback returns the shadow value.
- With `LED_PWM_FADE_EN`: DUTY0=3, FADE=1 -> active duty per period is 0,1,2,3,2,1,0,1…; without the macro, FADE reads 0.
